// File: rtl/fft64_mem_ctrl.sv
// fft64_mem_ctrl
// Memory/schedule controller for an in-place 64-point radix-2 DIT FFT.
// Samples are written to an external dual-port RAM in bit-reversed order.
// Six butterfly stages then read operand pairs, send them to an external
// butterfly of latency BF_LAT, and write the results back to the same
// addresses. Finally the 64 bins are streamed out in natural order.
//
// Ports
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Start                 begin a transform (used only in IDLE)
//   In_Valid, In_Data     input sample stream; In_Ready high in LOAD
//   Ram_En, We_A, We_B    RAM enable and per-port write enables
//   Addr_A, Addr_B        RAM addresses; DI_A/DI_B write data
//   DO_A, DO_B            RAM read data, one cycle after the address
//   Bf_Valid, Bf_X0/X1    butterfly operands; Bf_Tw_Addr twiddle index
//   Bf_Y0, Bf_Y1          butterfly results, BF_LAT cycles after Bf_Valid
//   Out_Valid/Last/Data   output bin stream
//   Busy                  high in every state except IDLE
//
// BF_LAT must be even and 0..8: an even latency puts every write slot on an
// odd cycle, so reads (even cycles) and writes never compete for a port.

module fft64_mem_ctrl #(
  parameter int WIDTH  = 32,
  parameter int BF_LAT = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               In_Valid,
  input  logic [2*WIDTH-1:0] In_Data,
  output logic               In_Ready,
  output logic               Ram_En,
  output logic               We_A,
  output logic               We_B,
  output logic [5:0]         Addr_A,
  output logic [5:0]         Addr_B,
  output logic [2*WIDTH-1:0] DI_A,
  output logic [2*WIDTH-1:0] DI_B,
  input  logic [2*WIDTH-1:0] DO_A,
  input  logic [2*WIDTH-1:0] DO_B,
  output logic               Bf_Valid,
  output logic [2*WIDTH-1:0] Bf_X0,
  output logic [2*WIDTH-1:0] Bf_X1,
  output logic [4:0]         Bf_Tw_Addr,
  input  logic [2*WIDTH-1:0] Bf_Y0,
  input  logic [2*WIDTH-1:0] Bf_Y1,
  output logic               Out_Valid,
  output logic               Out_Last,
  output logic [2*WIDTH-1:0] Out_Data,
  output logic               Busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_UNLOAD
  } state_t;

  // One entry per issued read: the pair of addresses that must be written
  // back once the butterfly result emerges.
  typedef struct packed {
    logic       v;
    logic [5:0] a;
    logic [5:0] b;
  } slot_t;

  localparam int         DL_DEPTH = BF_LAT + 1;
  localparam logic [6:0] C_LAST   = 7'(63 + BF_LAT);

  state_t      state_q, state_d;
  logic [5:0]  n_q;        // samples accepted in LOAD
  logic [5:0]  u_q;        // read index in UNLOAD
  logic [2:0]  s_q;        // butterfly stage
  logic [6:0]  c_q;        // cycle within stage, 0..63+BF_LAT
  slot_t       dl_q [DL_DEPTH];
  logic        bf_v_q;
  logic [4:0]  tw_q;
  logic        out_v_q;
  logic        out_last_q;

  logic        rd_slot;
  logic        wr_slot;
  logic [4:0]  k;
  logic [4:0]  h_mask;
  logic [4:0]  k_lo;
  logic [5:0]  rd_a;
  logic [5:0]  rd_b;
  logic [4:0]  rd_tw;

  function automatic logic [5:0] bitrev6(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = x[5-i];
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Butterfly address generation for the current read slot.
  // a = ((k >> s) << (s+1)) | (k & (h-1)), b = a + h; bit s of a is always
  // zero, so the add reduces to setting that bit.
  // ---------------------------------------------------------------------
  always_comb begin
    rd_slot = (state_q == S_CALC) && !c_q[6] && !c_q[0];
    k       = c_q[5:1];
    h_mask  = 5'((6'd1 << s_q) - 6'd1);
    k_lo    = k & h_mask;
    rd_a    = ((({1'b0, k} >> s_q) << (s_q + 3'd1))) | {1'b0, k_lo};
    rd_b    = rd_a | (6'd1 << s_q);
    rd_tw   = k_lo << (3'd5 - s_q);
    wr_slot = (state_q == S_CALC) && dl_q[DL_DEPTH-1].v;
  end

  // ---------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      u_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          n_q <= '0;
          u_q <= '0;
          s_q <= '0;
          c_q <= '0;
        end
        S_LOAD: begin
          if (In_Valid) n_q <= n_q + 6'd1;
        end
        S_CALC: begin
          if (c_q == C_LAST) begin
            c_q <= '0;
            s_q <= (s_q == 3'd5) ? 3'd0 : s_q + 3'd1;
          end else begin
            c_q <= c_q + 7'd1;
          end
        end
        S_UNLOAD: begin
          u_q <= u_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read-to-write address delay line and registered slot flags
  // ---------------------------------------------------------------------
  // NOTE: the delay line is an array but holds pending write-backs, so it is
  // cleared on reset; a stale valid bit would corrupt the RAM after an abort.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DL_DEPTH; i++) dl_q[i] <= '0;
      bf_v_q     <= 1'b0;
      tw_q       <= '0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      dl_q[0] <= '{v: rd_slot, a: rd_a, b: rd_b};
      for (int i = 1; i < DL_DEPTH; i++) dl_q[i] <= dl_q[i-1];
      bf_v_q     <= rd_slot;
      tw_q       <= rd_slot ? rd_tw : 5'd0;
      out_v_q    <= (state_q == S_UNLOAD);
      out_last_q <= (state_q == S_UNLOAD) && (u_q == 6'd63);
    end
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case statement can leave it holding a value (latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_LOAD;
      S_LOAD:   if (In_Valid && n_q == 6'd63) state_d = S_CALC;
      S_CALC:   if (c_q == C_LAST && s_q == 3'd5) state_d = S_UNLOAD;
      S_UNLOAD: if (u_q == 6'd63) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // RAM port drivers
  // ---------------------------------------------------------------------
  always_comb begin
    We_A   = 1'b0;
    We_B   = 1'b0;
    Addr_A = '0;
    Addr_B = '0;
    DI_A   = '0;
    DI_B   = '0;
    case (state_q)
      S_LOAD: begin
        if (In_Valid) begin
          We_A   = 1'b1;
          Addr_A = bitrev6(n_q);
          DI_A   = In_Data;
        end
      end
      S_CALC: begin
        if (rd_slot) begin
          Addr_A = rd_a;
          Addr_B = rd_b;
        end else if (wr_slot) begin
          We_A   = 1'b1;
          We_B   = 1'b1;
          Addr_A = dl_q[DL_DEPTH-1].a;
          Addr_B = dl_q[DL_DEPTH-1].b;
          DI_A   = Bf_Y0;
          DI_B   = Bf_Y1;
        end
      end
      S_UNLOAD: begin
        Addr_A = u_q;
      end
      default: ;
    endcase
  end

  assign Busy       = (state_q != S_IDLE);
  assign Ram_En     = (state_q != S_IDLE);
  assign In_Ready   = (state_q == S_LOAD);
  assign Bf_Valid   = bf_v_q;
  assign Bf_Tw_Addr = tw_q;
  assign Bf_X0      = DO_A;
  assign Bf_X1      = DO_B;
  assign Out_Valid  = out_v_q;
  assign Out_Last   = out_last_q;
  assign Out_Data   = DO_A;

endmodule

// File: doc/fft64_mem_ctrl.md
FFT64_MEM_CTRL -- requirements
Module: fft64_mem_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each real/imag component; complex word is 2*WIDTH bits.
REQ-002 Parameter BF_LAT, default 2, butterfly pipeline latency in cycles; SHALL be even and in the range 0..8.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  in  1  asynchronous active-low reset.
REQ-005 Start  in  1  begin one transform; honoured only in IDLE.
REQ-006 In_Valid / In_Data  in  1 / 2*WIDTH  input sample stream, natural order.
REQ-007 In_Ready  out  1  high only in LOAD.
REQ-008 Ram_En, We_A, We_B  out  1 each  RAM enable and per-port write enables.
REQ-009 Addr_A, Addr_B  out  6 each  RAM port addresses.
REQ-010 DI_A, DI_B  out  2*WIDTH each  RAM write data; DO_A, DO_B  in  2*WIDTH each  RAM read data, valid 1 cycle after address.
REQ-011 Bf_Valid  out  1, Bf_X0/Bf_X1  out  2*WIDTH, Bf_Tw_Addr  out  5  butterfly operands and twiddle index.
REQ-012 Bf_Y0/Bf_Y1  in  2*WIDTH  butterfly results, valid exactly BF_LAT cycles after Bf_Valid.
REQ-013 Out_Valid, Out_Last  out  1 each; Out_Data  out  2*WIDTH  result stream, natural bin order.
REQ-014 Busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, LOAD, CALC, UNLOAD; IDLE->LOAD on Start; LOAD->CALC after 64th accepted sample; CALC->UNLOAD after last cycle of stage 5; UNLOAD->IDLE after 64th read issue.
REQ-016 Ram_En SHALL be 1 in LOAD, CALC and UNLOAD and 0 in IDLE.
REQ-017 LOAD: each cycle with In_Valid=1, SHALL drive We_A=1, Addr_A=bitrev6(n), DI_A=In_Data, where n is the count of samples already accepted (0..63); In_Valid=0 stalls with no write.
REQ-018 CALC: stage s = 0..5; each stage lasts 64+BF_LAT cycles, indexed by cycle counter c = 0..63+BF_LAT.
REQ-019 Read slot at even c < 64: butterfly k=c/2, h=2^s, a=((k>>s)<<(s+1)) | (k & (h-1)), b=a+h; drive Addr_A=a, Addr_B=b, We_A=We_B=0.
REQ-020 Bf_Valid SHALL be 1 one cycle after each read slot; Bf_X0=DO_A, Bf_X1=DO_B are combinational pass-through; Bf_Tw_Addr=(k & (h-1))<<(5-s), registered and aligned to Bf_Valid.
REQ-021 Write slot at c=2k+1+BF_LAT: drive Addr_A=a, Addr_B=b of butterfly k from the address delay line, We_A=We_B=1, DI_A=Bf_Y0, DI_B=Bf_Y1.
REQ-022 Read slots are on even c and write slots on odd c, so the port address drivers never conflict; the next stage SHALL start at c=0 on the cycle after the last write (c=63+BF_LAT).
REQ-023 Total CALC duration SHALL be 6*(64+BF_LAT) cycles; no reads or writes occur outside the slots.
REQ-024 UNLOAD: cycle u = 0..63 drives Addr_A=u, We_A=0; Out_Valid=1 one cycle later with Out_Data=DO_A (pass-through); Out_Last=1 with bin 63; no output backpressure.
REQ-025 Start outside IDLE, and In_Valid outside LOAD, SHALL be ignored.
REQ-026 We_A, We_B, Bf_Valid and Out_Valid SHALL be 0 whenever no slot is active.

Reset
REQ-027 Rst_n=0 SHALL immediately force IDLE, clear all counters and delay lines, and drive every registered output to 0 (Busy, In_Ready, Ram_En, We_A, We_B, Bf_Valid, Out_Valid, Out_Last, Addr_A, Addr_B, Bf_Tw_Addr).
REQ-028 Reset mid-transform SHALL abandon the transform and SHALL NOT clear RAM contents; the next Start after reset runs a full transform.

Verification
REQ-029 Load order: Start, then feed In_Data=n for n=0..63 -> writes at Addr_A=bitrev6(n): n=1->32, n=6->24, n=63->63; In_Ready drops after the 64th sample.
REQ-030 Address/twiddle sequence: stage 0 k=0 -> a=0, b=1, tw=0; stage 2 k=5 -> a=9, b=13, tw=8; stage 5 k=31 -> a=31, b=63, tw=31.
REQ-031 Slot timing, BF_LAT=2: stage 0 read at c=0 -> Bf_Valid at c=1 -> write of addrs 0/1 at c=3; last write at c=65; stage 1 read at next cycle; CALC total 396 cycles.
REQ-032 End-to-end with bench butterfly model: impulse x[0]=1000+0j, others 0 -> 64 outputs each 1000+0j, Out_Last on the 64th output only.
REQ-033 Reset asserted at stage 3 c=10 -> all outputs 0 and Busy=0 immediately; a new Start plus 64 samples yields a correct full transform.
REQ-034 Start pulsed during CALC and In_Valid held high during UNLOAD -> no state change and no extra RAM writes.
